// File: rtl/regfile_write_scheduler.sv
// Write-port arbiter for the 32x32 register file: WB has fixed priority over the MDU,
// a scoreboard stalls ID on pending MDU results, and a starvation counter freezes the pipe.
module regfile_write_scheduler #(
   parameter int unsigned STARVE_LIMIT = 4,
   parameter int unsigned CNT_W        = 4
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        wb_valid,
   input  logic [4:0]  wb_reg,
   input  logic [31:0] wb_data,
   input  logic        wb_byte,
   input  logic        md_valid,
   input  logic [4:0]  md_reg,
   input  logic [31:0] md_data,
   output logic        md_ready,
   input  logic        issue_valid,
   input  logic [4:0]  issue_reg,
   input  logic [4:0]  Rs_ID,
   input  logic [4:0]  Rt_ID,
   input  logic [4:0]  Rd_ID,
   output logic        stall_ID,
   output logic        pipe_hold,
   output logic        RegWrite,
   output logic [4:0]  RegWr_ID,
   output logic [31:0] Write_data,
   output logic        Load_Byte_control
);

   logic             md_grant;
   logic [31:0]      pend_q, pend_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hold_q, hold_d;
   logic             we_q, we_d;
   logic [4:0]       id_q, id_d;
   logic [31:0]      data_q, data_d;
   logic             byte_q, byte_d;

   assign md_grant = !Rst && md_valid && !wb_valid;
   assign md_ready = md_grant;

   always_comb begin
      we_d   = 1'b0;
      id_d   = id_q;
      data_d = data_q;
      byte_d = byte_q;
      if (wb_valid) begin
         we_d   = (wb_reg != 5'd0);
         id_d   = wb_reg;
         data_d = wb_data;
         byte_d = wb_byte;
      end else if (md_grant) begin
         we_d   = (md_reg != 5'd0);
         id_d   = md_reg;
         data_d = md_data;
         byte_d = 1'b0;
      end
   end

   // Clear before set: an issue in the same cycle belongs to the newer op and must win.
   always_comb begin
      pend_d = pend_q;
      if (md_grant)
         pend_d[md_reg] = 1'b0;
      if (issue_valid && issue_reg != 5'd0)
         pend_d[issue_reg] = 1'b1;
      pend_d[0] = 1'b0;
   end

   always_comb begin
      cnt_d = '0;
      if (md_valid && !md_grant)
         cnt_d = (cnt_q < CNT_W'(STARVE_LIMIT)) ? cnt_q + CNT_W'(1) : cnt_q;
      hold_d = hold_q;
      if (md_grant)
         hold_d = 1'b0;
      else if (cnt_d == CNT_W'(STARVE_LIMIT))
         hold_d = 1'b1;
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         pend_q <= '0;
         cnt_q  <= '0;
         hold_q <= 1'b0;
         we_q   <= 1'b0;
         id_q   <= '0;
         data_q <= '0;
         byte_q <= 1'b0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
         hold_q <= hold_d;
         we_q   <= we_d;
         id_q   <= id_d;
         data_q <= data_d;
         byte_q <= byte_d;
      end
   end

   assign stall_ID          = pend_q[Rs_ID] | pend_q[Rt_ID] | pend_q[Rd_ID];
   assign pipe_hold         = hold_q;
   assign RegWrite          = we_q;
   assign RegWr_ID          = id_q;
   assign Write_data        = data_q;
   assign Load_Byte_control = byte_q;

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Randomized bench for regfile_write_scheduler against a behavioural model of arbitration,
// scoreboard and starvation rules.
module tb_regfile_write_scheduler;

   localparam int LIMIT = 4;

   logic        Clk = 1'b0;
   logic        Rst;
   logic        wb_valid, wb_byte, md_valid, issue_valid;
   logic [4:0]  wb_reg, md_reg, issue_reg, Rs_ID, Rt_ID, Rd_ID;
   logic [31:0] wb_data, md_data;
   logic        md_ready, stall_ID, pipe_hold, RegWrite, Load_Byte_control;
   logic [4:0]  RegWr_ID;
   logic [31:0] Write_data;

   regfile_write_scheduler #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
      .Clk(Clk), .Rst(Rst),
      .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_byte(wb_byte),
      .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_ready(md_ready),
      .issue_valid(issue_valid), .issue_reg(issue_reg),
      .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Rd_ID(Rd_ID), .stall_ID(stall_ID),
      .pipe_hold(pipe_hold), .RegWrite(RegWrite), .RegWr_ID(RegWr_ID),
      .Write_data(Write_data), .Load_Byte_control(Load_Byte_control)
   );

   always #5 Clk = ~Clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   bit          m_pend [32];
   bit          m_we, m_byte, m_hold;
   logic [4:0]  m_id;
   logic [31:0] m_data;
   int          m_refused;
   bit          last_grant;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
      end
   endtask

   function automatic bit pend_of(input logic [4:0] r);
      return (r != 5'd0) && m_pend[r];
   endfunction

   // Checks at negedge against the model, then advances the model across the next posedge.
   task automatic step();
      bit exp_ready, exp_stall;
      @(negedge Clk);
      exp_ready = !Rst && md_valid && !wb_valid;
      exp_stall = pend_of(Rs_ID) || pend_of(Rt_ID) || pend_of(Rd_ID);
      chk("md_ready", 32'(md_ready), 32'(exp_ready));
      chk("stall_ID", 32'(stall_ID), 32'(exp_stall));
      chk("pipe_hold", 32'(pipe_hold), 32'(m_hold));
      chk("RegWrite", 32'(RegWrite), 32'(m_we));
      if (m_we) begin
         chk("RegWr_ID", 32'(RegWr_ID), 32'(m_id));
         chk("Write_data", Write_data, m_data);
         chk("Load_Byte", 32'(Load_Byte_control), 32'(m_byte));
      end
      last_grant = exp_ready;
      if (Rst) begin
         foreach (m_pend[i]) m_pend[i] = 1'b0;
         m_we = 0; m_hold = 0; m_refused = 0;
      end else begin
         m_we = 0;
         if (wb_valid) begin
            m_we = (wb_reg != 0); m_id = wb_reg; m_data = wb_data; m_byte = wb_byte;
         end else if (exp_ready) begin
            m_we = (md_reg != 0); m_id = md_reg; m_data = md_data; m_byte = 0;
         end
         if (exp_ready) m_pend[md_reg] = 1'b0;
         if (issue_valid && issue_reg != 0) m_pend[issue_reg] = 1'b1;
         m_refused = (md_valid && !exp_ready) ? m_refused + 1 : 0;
         if (exp_ready) m_hold = 0;
         else if (m_refused == LIMIT) m_hold = 1;
      end
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      Rst = 0; wb_valid = 0; wb_byte = 0; md_valid = 0; issue_valid = 0;
      wb_reg = 0; md_reg = 0; issue_reg = 0; Rs_ID = 0; Rt_ID = 0; Rd_ID = 0;
      wb_data = 0; md_data = 0;
   endtask

   initial begin
      m_we = 0; m_byte = 0; m_hold = 0; m_id = 0; m_data = 0; m_refused = 0;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      idle();
      // Reset with live requests
      Rst = 1; md_valid = 1; md_reg = 5; issue_valid = 1; issue_reg = 3;
      @(posedge Clk); #1;
      step(); step();
      chk("reset_RegWrite", 32'(RegWrite), 32'd0);
      chk("reset_pipe_hold", 32'(pipe_hold), 32'd0);
      idle(); Rs_ID = 3; Rd_ID = 5;
      step();
      // WB write, then load-byte write
      wb_valid = 1; wb_reg = 8; wb_data = 32'h0A12; step();
      wb_byte = 1; wb_data = 32'h0FFFFF; step();
      idle(); step();
      // Scoreboard set, hazard, MDU clear
      issue_valid = 1; issue_reg = 19; step();
      idle(); Rs_ID = 19; step();
      md_valid = 1; md_reg = 19; md_data = 32'h1234; step();
      idle(); Rs_ID = 19; step(); step();
      // Issue to reg 0 never stalls
      issue_valid = 1; issue_reg = 0; step();
      idle(); step();
      // Starvation: WB keeps winning, then yields
      md_valid = 1; md_reg = 7; md_data = 32'hBEEF; wb_valid = 1; wb_reg = 2; wb_data = 32'h55;
      repeat (LIMIT + 2) step();
      chk("starve_hold_set", 32'(pipe_hold), 32'd1);
      wb_valid = 0; step();
      md_valid = 0; step(); step();
      // Same-cycle set/clear of reg 19
      issue_valid = 1; issue_reg = 19; step();
      md_valid = 1; md_reg = 19; md_data = 32'h77; Rt_ID = 19; step();
      idle(); Rt_ID = 19; step(); step();
      // Randomized traffic respecting the hold contract (rare violations/resets included)
      for (int i = 0; i < 3000; i++) begin
         Rst = ($urandom_range(0, 199) == 0);
         wb_valid = (m_hold && $urandom_range(0, 19) != 0) ? 1'b0 : 1'($urandom_range(0, 2) != 0);
         wb_reg = 5'($urandom_range(0, 7)); wb_data = $urandom; wb_byte = 1'($urandom);
         if (!(md_valid && !last_grant)) begin
            md_valid = 1'($urandom_range(0, 2) == 0);
            md_reg = 5'($urandom_range(0, 7)); md_data = $urandom;
         end
         issue_valid = 1'($urandom_range(0, 3) == 0); issue_reg = 5'($urandom_range(0, 7));
         Rs_ID = 5'($urandom_range(0, 7)); Rt_ID = 5'($urandom_range(0, 7));
         Rd_ID = 5'($urandom_range(0, 7));
         step();
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
- Owns the single write port of the 32x32 register file.
- Two writers share it: the pipeline writeback stage (WB) and the multicycle multiply/divide unit (MDU). It arbitrates between them and drives RegWrite/RegWr_ID/Write_data/Load_Byte_control.
- Keeps a 32-bit scoreboard of registers with an outstanding MDU result and stalls ID on hazards against them.
- A starvation counter forces a pipeline hold so the MDU result eventually reaches the write port.

Parameters:
- STARVE_LIMIT, 4: consecutive cycles a valid MDU request may be refused before pipe_hold asserts (1..15).
- CNT_W, 4: width of the starvation counter.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Rst  in  1  synchronous, active-high reset.
- wb_valid  in  1  WB has a register write this cycle.
- wb_reg  in  5  WB destination register.
- wb_data  in  32  WB write data.
- wb_byte  in  1  WB write is a load-byte (zero-extend low byte).
- md_valid  in  1  MDU result ready to write.
- md_reg  in  5  MDU destination register.
- md_data  in  32  MDU result.
- md_ready  out  1  MDU request accepted this cycle (combinational).
- issue_valid  in  1  an MDU op is issued from ID this cycle.
- issue_reg  in  5  destination of the issued MDU op.
- Rs_ID  in  5  ID source register.
- Rt_ID  in  5  ID source register.
- Rd_ID  in  5  ID destination register (WAW check).
- stall_ID  out  1  hazard stall to ID (combinational).
- pipe_hold  out  1  registered pipeline freeze request.
- RegWrite  out  1  to register file.
- RegWr_ID  out  5  to register file.
- Write_data  out  32  to register file.
- Load_Byte_control  out  1  to register file.

Behaviour:
- Reset (Rst=1 at posedge):
  - RegWrite, RegWr_ID, Write_data, Load_Byte_control, pipe_hold, scoreboard and starvation counter all clear to 0.
  - md_ready=0 while Rst=1.
- Arbitration, per cycle:
  - WB has fixed priority. md_ready = !Rst & md_valid & !wb_valid.
  - Pipeline contract: wb_valid=0 in every cycle where pipe_hold=1.
- Write port timing:
  - Outputs are registered. The grant made in cycle t drives the write-port outputs during t+1, and the register file writes on the posedge ending t+1. Latency is 1 cycle.
  - WB granted: RegWrite=1, RegWr_ID=wb_reg, Write_data=wb_data, Load_Byte_control=wb_byte.
  - MDU granted: RegWrite=1, RegWr_ID=md_reg, Write_data=md_data, Load_Byte_control=0.
  - No grant: RegWrite=0; other write-port outputs hold their last value.
  - A grant to reg 0 is consumed (md_ready still 1), but RegWrite=0 is driven.
- Scoreboard pend[31:0]:
  - issue_valid with issue_reg!=0 sets pend[issue_reg].
  - MDU grant (md_valid & md_ready) clears pend[md_reg].
  - Set and clear of the same register in one cycle: set wins, since it belongs to the newer op.
  - pend[0] is always 0.
- stall_ID = pend[Rs_ID] | pend[Rt_ID] | pend[Rd_ID].
  - Register 0 index never stalls.
  - Pure combinational lookup of registered state; an issue in cycle t stalls from t+1.
- Starvation:
  - Counter increments when md_valid & !md_ready, saturating at STARVE_LIMIT.
  - Clears on MDU grant or when md_valid=0.
  - pipe_hold register is set at the posedge where the counter's next value equals STARVE_LIMIT. It clears at the posedge following the MDU grant.
  - While pipe_hold=1, wb_valid=0 by contract, so the MDU is granted that same cycle.
  - If wb_valid=1 while pipe_hold=1 (contract violation): WB still wins, and hold stays asserted until the MDU is granted.
- Reset mid-operation: a pending MDU request is dropped; all pend bits are lost and the pipeline flushes; no write occurs in the cycle after reset.
- Simultaneous WB and MDU requests to the same register: WB is written first, the MDU later. Ordering is correct because the pend bit blocked any younger WB writer at ID.

Test Plan:
- Reset: Rst=1 for 2 cycles with md_valid=1 and wb_valid=1 → RegWrite=0, md_ready=0, pipe_hold=0, stall_ID=0.
- WB only: wb_valid=1, wb_reg=8, wb_data=32'h0A12 → next cycle RegWrite=1, RegWr_ID=8, Write_data=32'h0A12; registers_i[8]=32'h0A12 after that posedge.
- Byte write: wb_byte=1, wb_reg=8, wb_data=32'h0FFFFF → Load_Byte_control=1; registers_i[8]=32'h000000FF.
- Scoreboard:
  - issue_valid=1, issue_reg=19, then Rs_ID=19 → stall_ID=1 from the next cycle.
  - md_valid=1, md_reg=19, md_data=32'h1234 with wb_valid=0 → md_ready=1, write next cycle, stall_ID=0 one cycle after the grant.
  - Also check: issue to reg 0 never stalls.
- Starvation (STARVE_LIMIT=4): md_valid=1, wb_valid=1 continuously → md_ready=0 for 4 cycles, then pipe_hold=1. Drop wb_valid → md_ready=1 that cycle, pipe_hold=0 one cycle later, counter back to 0.
- Same-cycle set/clear: issue_reg=19 while an MDU grant to reg 19 occurs → pend[19] stays 1 and stall_ID on Rt_ID=19 remains asserted.
